neopixel_array_ctl: RTL and testbench

NEOPIXEL_ARRAY_CTL -- requirements
Module: neopixel_array_ctl

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_bit_enc.sv | 62 ++++++
 rtl/neopixel_array_ctl.sv | 211 +++++++++++++++++++++
 tb/tb_neopixel_array_ctl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared command codes and state encodings for the WS2812 array controller.
package ws2812_pkg;

  localparam logic [7:0] CMD_CH_SEL   = 8'h2A;
  localparam logic [7:0] CMD_ADDR_SET = 8'h2B;
  localparam logic [7:0] CMD_WR_START = 8'h2C;
  localparam logic [7:0] CMD_REFRESH  = 8'h2D;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_LATCH} state_t;
  typedef enum logic [1:0] {LANE_G, LANE_R, LANE_B} lane_t;
  typedef enum logic [1:0] {ARG_NONE, ARG_MASK, ARG_ADDR} arg_t;

  function automatic lane_t next_lane(input lane_t cur);
    case (cur)
      LANE_G:  return LANE_R;
      LANE_R:  return LANE_B;
      default: return LANE_G;
    endcase
  endfunction

endpackage

// File: rtl/ws2812_bit_enc.sv
// One WS2812 channel: frame buffer, 24-bit shift register and the high-time
// compare against the bit timer shared by all channels.
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int LED_NUM = 64,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int IDX_W   = 6,
  parameter int TW      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_lane,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             ld,
  input  logic             shift,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             drive,
  input  logic [TW-1:0]    tmr_next,
  output logic             data_out
);

  logic [23:0] mem [LED_NUM];
  logic [23:0] shift_reg;
  logic [23:0] shift_next;

  // The buffer is deliberately not reset so a reset never disturbs a frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_lane)
        LANE_G:  mem[wr_idx][23:16] <= wr_data;
        LANE_R:  mem[wr_idx][15:8]  <= wr_data;
        LANE_B:  mem[wr_idx][7:0]   <= wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_next = shift_reg;
    if (ld) begin
      shift_next = mem[rd_idx];
    end else if (shift) begin
      shift_next = {shift_reg[22:0], 1'b0};
    end
  end

  // Output is the registered view of the bit that will be on the wire next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      data_out  <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      data_out  <= drive && (tmr_next < (shift_next[23] ? TW'(T1H_CYC) : TW'(T0H_CYC)));
    end
  end

endmodule

// File: rtl/neopixel_array_ctl.sv
// Multi-channel WS2812 controller: byte-wide host command decoder plus a
// refresh sequencer that streams all channel buffers in lock step.
module neopixel_array_ctl
  import ws2812_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int LED_NUM = 64,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63,
  parameter int RST_CYC = 3000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              dc_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic              busy_out,
  output logic [CH_NUM-1:0] ws2812_data_out
);

  localparam int IDX_W = $clog2(LED_NUM);
  localparam int TW    = $clog2(BIT_CYC + 1);
  localparam int LW    = $clog2(RST_CYC + 1);

  logic              accept;
  logic              is_cmd;
  logic              is_data;
  logic              refresh_go;
  logic              wr_fire;
  logic [CH_NUM-1:0] mask;
  logic [CH_NUM-1:0] ref_mask;
  logic [IDX_W-1:0]  idx;
  lane_t             lane;
  arg_t              arg;
  logic              wr_mode;

  state_t            state;
  logic [TW-1:0]     tmr;
  logic [TW-1:0]     tmr_next;
  logic [4:0]        bit_cnt;
  logic [IDX_W-1:0]  led_cnt;
  logic [IDX_W-1:0]  rd_idx;
  logic [LW-1:0]     lat_cnt;
  logic              bit_end;
  logic              led_end;
  logic              frame_end;
  logic              ld;
  logic              shift;
  logic              send_next;

  // busy_out also covers the final LATCH cycle, so that strobe is dropped too.
  assign accept     = byte_rdy_in && !busy_out;
  assign is_cmd     = accept && !dc_in;
  assign is_data    = accept && dc_in;
  assign refresh_go = is_cmd && (byte_data_in == CMD_REFRESH);
  assign wr_fire    = is_data && (arg == ARG_NONE) && wr_mode;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mask    <= '0;
      idx     <= '0;
      lane    <= LANE_G;
      arg     <= ARG_NONE;
      wr_mode <= 1'b0;
    end else if (is_cmd) begin
      lane    <= LANE_G;
      arg     <= ARG_NONE;
      wr_mode <= 1'b0;
      case (byte_data_in)
        CMD_CH_SEL:   arg <= ARG_MASK;
        CMD_ADDR_SET: arg <= ARG_ADDR;
        CMD_WR_START: wr_mode <= 1'b1;
        default:      ;
      endcase
    end else if (is_data) begin
      case (arg)
        ARG_MASK: begin
          mask <= byte_data_in[CH_NUM-1:0];
          arg  <= ARG_NONE;
        end
        ARG_ADDR: begin
          if ({24'd0, byte_data_in} >= LED_NUM) begin
            idx <= IDX_W'(LED_NUM - 1);
          end else begin
            idx <= byte_data_in[IDX_W-1:0];
          end
          arg <= ARG_NONE;
        end
        default: begin
          if (wr_mode) begin
            lane <= next_lane(lane);
            if (lane == LANE_B) begin
              idx <= (idx == IDX_W'(LED_NUM - 1)) ? '0 : idx + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bit_end   = (tmr == TW'(BIT_CYC - 1));
  assign led_end   = (bit_cnt == 5'd23);
  assign frame_end = led_end && (led_cnt == IDX_W'(LED_NUM - 1));

  // Look-ahead controls: describe what the encoders put on the wire next cycle.
  always_comb begin
    ld        = 1'b0;
    shift     = 1'b0;
    send_next = 1'b0;
    tmr_next  = '0;
    rd_idx    = led_cnt + IDX_W'(1);
    case (state)
      ST_LOAD: begin
        ld        = 1'b1;
        rd_idx    = '0;
        send_next = 1'b1;
      end
      ST_SEND: begin
        if (!bit_end) begin
          tmr_next  = tmr + TW'(1);
          send_next = 1'b1;
        end else if (!led_end) begin
          shift     = 1'b1;
          send_next = 1'b1;
        end else if (!frame_end) begin
          ld        = 1'b1;
          send_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      busy_out <= 1'b0;
      ref_mask <= '0;
      tmr      <= '0;
      bit_cnt  <= '0;
      led_cnt  <= '0;
      lat_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (refresh_go) begin
            state    <= ST_LOAD;
            busy_out <= 1'b1;
            ref_mask <= mask;
          end
        end
        ST_LOAD: begin
          state   <= ST_SEND;
          tmr     <= '0;
          bit_cnt <= '0;
          led_cnt <= '0;
        end
        ST_SEND: begin
          tmr <= tmr_next;
          if (bit_end) begin
            if (!led_end) begin
              bit_cnt <= bit_cnt + 5'd1;
            end else begin
              bit_cnt <= '0;
              if (frame_end) begin
                state   <= ST_LATCH;
                lat_cnt <= '0;
              end else begin
                led_cnt <= led_cnt + IDX_W'(1);
              end
            end
          end
        end
        ST_LATCH: begin
          if (lat_cnt == LW'(RST_CYC - 1)) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    ws2812_bit_enc #(
      .LED_NUM (LED_NUM),
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .IDX_W   (IDX_W),
      .TW      (TW)
    ) u_enc (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .wr_en    (wr_fire && mask[ch]),
      .wr_lane  (lane),
      .wr_idx   (idx),
      .wr_data  (byte_data_in),
      .ld       (ld),
      .shift    (shift),
      .rd_idx   (rd_idx),
      .drive    (send_next && ref_mask[ch]),
      .tmr_next (tmr_next),
      .data_out (ws2812_data_out[ch])
    );
  end

endmodule

// File: tb/tb_neopixel_array_ctl.sv
// Self-checking bench for neopixel_array_ctl: table vectors, hand sequences
// for drop/reset corners and randomized traffic against a byte-level model.
module tb_neopixel_array_ctl;

  localparam int CH    = 2;
  localparam int LED   = 2;
  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int BITC  = 6;
  localparam int RSTC  = 10;
  localparam int NBITS = LED * 24;
  localparam int CAP   = 1 + NBITS * BITC + RSTC + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dc = 1'b0;
  logic          byte_rdy = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          busy;
  logic [CH-1:0] ws;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model of the host-visible state.
  logic [23:0]   m_buf [CH][LED];
  logic [CH-1:0] m_mask;
  logic [CH-1:0] m_refmask;
  int            m_idx;
  int            m_cnt;
  int            m_arg;
  bit            m_wr;

  logic [319:0]  cap_busy;
  logic [319:0]  cap_w [CH];
  logic [23:0]   dec_word [CH][LED];

  typedef struct packed {
    logic [7:0]  wmask;
    logic [7:0]  addr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  rmask;
    logic [23:0] e00;
    logic [23:0] e01;
    logic [23:0] e10;
    logic [23:0] e11;
  } vec_t;

  vec_t tbl [5];

  neopixel_array_ctl #(
    .CH_NUM  (CH),
    .LED_NUM (LED),
    .T0H_CYC (T0H),
    .T1H_CYC (T1H),
    .BIT_CYC (BITC),
    .RST_CYC (RSTC)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .dc_in           (dc),
    .byte_rdy_in     (byte_rdy),
    .byte_data_in    (byte_data),
    .busy_out        (busy),
    .ws2812_data_out (ws)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_mask = '0;
    m_idx  = 0;
    m_cnt  = 0;
    m_arg  = 0;
    m_wr   = 1'b0;
  endtask

  task automatic modelByte(input logic d_c, input logic [7:0] d);
    if (!d_c) begin
      m_cnt = 0;
      m_arg = 0;
      m_wr  = 1'b0;
      case (d)
        8'h2A:   m_arg = 1;
        8'h2B:   m_arg = 2;
        8'h2C:   m_wr = 1'b1;
        8'h2D:   m_refmask = m_mask;
        default: ;
      endcase
    end else if (m_arg == 1) begin
      m_mask = d[CH-1:0];
      m_arg  = 0;
    end else if (m_arg == 2) begin
      m_idx = (int'(d) >= LED) ? LED - 1 : int'(d);
      m_arg = 0;
    end else if (m_wr) begin
      for (int c = 0; c < CH; c++) begin
        if (m_mask[c]) m_buf[c][m_idx][23 - 8 * m_cnt -: 8] = d;
      end
      m_cnt++;
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % LED;
      end
    end
  endtask

  // Drives one byte strobe for one cycle; called right after a falling edge.
  task automatic applyStimulus(input logic d_c, input logic [7:0] d);
    dc        = d_c;
    byte_data = d;
    byte_rdy  = 1'b1;
    modelByte(d_c, d);
    @(negedge clk);
    byte_rdy = 1'b0;
  endtask

  task automatic runRefresh(input bit inject, input int abort_at);
    logic [319:0] exp_busy;
    logic [319:0] exp_w;
    bit           aborted;
    int           b;
    int           hi;
    int           cnt;
    logic         bitv;
    aborted  = 1'b0;
    cap_busy = '0;
    for (int c = 0; c < CH; c++) cap_w[c] = '0;
    applyStimulus(1'b0, 8'h2D);
    for (int s = 0; s < CAP; s++) begin
      cap_busy[s] = busy;
      for (int c = 0; c < CH; c++) cap_w[c][s] = ws[c];
      if (s == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 320'(busy), 320'(0));
        checkOutput("abort ws", 320'(ws), 320'(0));
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        aborted = 1'b1;
        break;
      end
      if (inject) begin
        if (s == 50) begin
          dc = 1'b0; byte_data = 8'h2A; byte_rdy = 1'b1;
        end else if (s == 52) begin
          dc = 1'b1; byte_data = 8'h01; byte_rdy = 1'b1;
        end else if (s == CAP - 2) begin
          dc = 1'b0; byte_data = 8'h2A; byte_rdy = 1'b1;
        end else begin
          byte_rdy = 1'b0;
        end
      end
      @(negedge clk);
    end
    if (!aborted) begin
      exp_busy = '0;
      for (int s = 0; s < CAP - 1; s++) exp_busy[s] = 1'b1;
      checkOutput("busy window", cap_busy, exp_busy);
      checkOutput("busy cycles", 320'($countones(cap_busy)), 320'(CAP - 1));
      for (int c = 0; c < CH; c++) begin
        exp_w = '0;
        if (m_refmask[c]) begin
          for (int j = 0; j < NBITS * BITC; j++) begin
            b    = j / BITC;
            bitv = m_buf[c][b / 24][23 - (b % 24)];
            hi   = bitv ? T1H : T0H;
            exp_w[j + 1] = ((j % BITC) < hi);
          end
        end
        checkOutput($sformatf("ch%0d wave", c), cap_w[c], exp_w);
        for (int l = 0; l < LED; l++) begin
          for (int k = 0; k < 24; k++) begin
            cnt = 0;
            for (int t = 0; t < BITC; t++) begin
              if (cap_w[c][1 + (l * 24 + k) * BITC + t]) cnt++;
            end
            dec_word[c][l][23 - k] = (2 * cnt > T0H + T1H);
          end
        end
      end
    end
  endtask

  task automatic selectAndRefresh(input logic [7:0] rmask, input bit inject, input int abort_at);
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, rmask);
    runRefresh(inject, abort_at);
  endtask

  task automatic writeTriple(input logic [7:0] wmask, input logic [7:0] addr,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, wmask);
    applyStimulus(1'b0, 8'h2B);
    applyStimulus(1'b1, addr);
    applyStimulus(1'b0, 8'h2C);
    applyStimulus(1'b1, b0);
    applyStimulus(1'b1, b1);
    applyStimulus(1'b1, b2);
  endtask

  task automatic checkWords(input string tag, input logic [23:0] e00, input logic [23:0] e01,
                            input logic [23:0] e10, input logic [23:0] e11);
    checkOutput($sformatf("%s ch0 led0", tag), 320'(dec_word[0][0]), 320'(e00));
    checkOutput($sformatf("%s ch0 led1", tag), 320'(dec_word[0][1]), 320'(e01));
    checkOutput($sformatf("%s ch1 led0", tag), 320'(dec_word[1][0]), 320'(e10));
    checkOutput($sformatf("%s ch1 led1", tag), 320'(dec_word[1][1]), 320'(e11));
  endtask

  initial begin
    logic [7:0] v;
    int         n;

    tbl[0] = '{8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h02, 24'h000000, 24'h000000, 24'h800000, 24'h800000};
    tbl[1] = '{8'h03, 8'h00, 8'h12, 8'h34, 8'h56, 8'h03, 24'h123456, 24'hFFFFFF, 24'h123456, 24'h800000};
    tbl[2] = '{8'h02, 8'h05, 8'hA5, 8'h0F, 8'hF0, 8'h03, 24'h123456, 24'hFFFFFF, 24'h123456, 24'hA50FF0};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 24'h123456, 24'hFFFFFF, 24'h123456, 24'hA50FF0};
    tbl[4] = '{8'h06, 8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 24'h123456, 24'hFFFFFF, 24'h000000, 24'h000000};

    modelReset();
    m_refmask = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 320'(busy), 320'(0));
    checkOutput("reset ws", 320'(ws), 320'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Both LEDs of both channels get 0x800000.
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h03);
    applyStimulus(1'b0, 8'h2B);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h2C);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h80);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h00);
    end
    runRefresh(1'b0, -1);
    checkOutput("load cycle low", 320'(cap_w[0][0]), 320'(0));
    for (int c = 0; c < CH; c++) begin
      checkOutput($sformatf("ch%0d first bit", c), 320'(cap_w[c][6:1]), 320'(6'b001111));
      checkOutput($sformatf("ch%0d second bit", c), 320'(cap_w[c][12:7]), 320'(6'b000011));
      checkOutput($sformatf("ch%0d last bit", c), 320'(cap_w[c][288:283]), 320'(6'b000011));
      checkOutput($sformatf("ch%0d latch low", c), 320'(cap_w[c][299:289]), 320'(0));
    end
    checkWords("init", 24'h800000, 24'h800000, 24'h800000, 24'h800000);

    for (int i = 0; i < 5; i++) begin
      writeTriple(tbl[i].wmask, tbl[i].addr, tbl[i].b0, tbl[i].b1, tbl[i].b2);
      selectAndRefresh(tbl[i].rmask, 1'b0, -1);
      checkWords($sformatf("vec%0d", i), tbl[i].e00, tbl[i].e01, tbl[i].e10, tbl[i].e11);
    end

    // Six bytes from LED 1: second triple wraps to LED 0.
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h03);
    applyStimulus(1'b0, 8'h2B);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b0, 8'h2C);
    applyStimulus(1'b1, 8'hC0);
    applyStimulus(1'b1, 8'hC1);
    applyStimulus(1'b1, 8'hC2);
    applyStimulus(1'b1, 8'hD0);
    applyStimulus(1'b1, 8'hD1);
    applyStimulus(1'b1, 8'hD2);
    runRefresh(1'b0, -1);
    checkWords("wrap", 24'hD0D1D2, 24'hC0C1C2, 24'hD0D1D2, 24'hC0C1C2);

    // Bytes during busy and on the last latch cycle must vanish.
    selectAndRefresh(8'h03, 1'b1, -1);
    applyStimulus(1'b1, 8'h00);
    runRefresh(1'b0, -1);
    checkWords("drop", 24'hD0D1D2, 24'hC0C1C2, 24'hD0D1D2, 24'hC0C1C2);

    // Reset at bit 30, then the mask is cleared but the buffer survives.
    selectAndRefresh(8'h03, 1'b0, 1 + 30 * BITC);
    runRefresh(1'b0, -1);
    checkWords("post reset mask", 24'h0, 24'h0, 24'h0, 24'h0);
    selectAndRefresh(8'h03, 1'b0, -1);
    checkWords("replay", 24'hD0D1D2, 24'hC0C1C2, 24'hD0D1D2, 24'hC0C1C2);

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 9))
          0: applyStimulus(1'b0, 8'h2A);
          1: applyStimulus(1'b0, 8'h2B);
          2, 3: applyStimulus(1'b0, 8'h2C);
          4: begin
            v = 8'h30 | 8'($urandom_range(0, 15));
            applyStimulus(1'b0, v);
          end
          default: begin
            v = 8'($urandom);
            applyStimulus(1'b1, v);
          end
        endcase
      end
      v = 8'($urandom_range(0, 7));
      selectAndRefresh(v, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
